// File: rtl/game_ctrl_param_if.sv
// Player/controller signal bundle for game_ctrl_param.
// master drives the player inputs; slave is the controller side.
interface game_ctrl_param_if #(
  parameter int unsigned IW      = 4,
  parameter int unsigned RW      = 2,
  parameter int unsigned SCORE_W = 8
);
  logic               game_start;
  logic               pause;
  logic               hit;
  logic [IW-1:0]      hit_index;
  logic               mole_active;
  logic [IW-1:0]      mole_index;
  logic               hit_success;
  logic               miss;
  logic [RW-1:0]      round_level;
  logic [3:0]         round_hits;
  logic [SCORE_W-1:0] total_score;
  logic               game_over;
  logic               game_won;

  modport master (
    output game_start, pause, hit, hit_index,
    input  mole_active, mole_index, hit_success, miss,
    input  round_level, round_hits, total_score, game_over, game_won
  );

  modport slave (
    input  game_start, pause, hit, hit_index,
    output mole_active, mole_index, hit_success, miss,
    output round_level, round_hits, total_score, game_over, game_won
  );
endinterface

// File: rtl/game_ctrl_param.sv
// Whack-a-mole game controller: timed rounds of moles on N_HOLES holes,
// LFSR-driven hole choice, scoring, pause and multi-round progression.
module game_ctrl_param #(
  parameter int unsigned N_HOLES    = 16,
  parameter int unsigned N_ROUNDS   = 3,
  parameter int unsigned PASS_HITS  = 3,
  parameter int          INT0       = 12500000,
  parameter int          INT_STEP   = 2500000,
  parameter int          DUR0       = 10000000,
  parameter int          DUR_STEP   = 2500000,
  parameter int          MOLES0     = 4,
  parameter int          MOLES_STEP = 2,
  parameter int unsigned SCORE_W    = 8
) (
  input logic              clk,
  input logic              rst,
  game_ctrl_param_if.slave ctrl
);
  localparam int unsigned IW = $clog2(N_HOLES);
  localparam int unsigned RW = (N_ROUNDS > 1) ? $clog2(N_ROUNDS) : 1;

  typedef enum logic [2:0] {
    StIdle, StConfig, StGap, StShow, StRoundEnd, StGameOver
  } state_e;

  state_e             state_q;
  logic [26:0]        timer_q, gap_q, show_q;
  logic [3:0]         moles_left_q, round_hits_q;
  logic [15:0]        lfsr_q;
  logic [IW-1:0]      mole_index_q;
  logic               mole_active_q, hit_success_q, miss_q, game_over_q, game_won_q;
  logic [RW-1:0]      round_q;
  logic [SCORE_W-1:0] score_q;

  logic signed [31:0] gap_calc, show_calc, moles_calc;
  logic [26:0]        gap_cfg, show_cfg;
  logic [3:0]         moles_cfg, hits_next, moles_dec;
  logic [15:0]        lfsr_next;
  logic [IW-1:0]      cand, next_mole;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_next;
  logic               frozen, correct_hit, gap_done, show_timeout, round_pass, last_round;

  always_comb begin
    gap_calc   = INT0 - INT_STEP * $signed(32'(round_q));
    show_calc  = DUR0 - DUR_STEP * $signed(32'(round_q));
    moles_calc = MOLES0 + MOLES_STEP * $signed(32'(round_q));
    gap_cfg    = (gap_calc < 32'sd1) ? 27'd1 : gap_calc[26:0];
    show_cfg   = (show_calc < 32'sd1) ? 27'd1 : show_calc[26:0];
    moles_cfg  = (moles_calc > 32'sd15) ? 4'd15 : moles_calc[3:0];

    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    cand      = lfsr_q[IW-1:0];
    // Never show the same hole twice in a row.
    next_mole = (cand == mole_index_q) ? cand + IW'(1) : cand;

    frozen       = ctrl.pause && (state_q == StGap || state_q == StShow);
    correct_hit  = ctrl.hit && (ctrl.hit_index == mole_index_q);
    gap_done     = (timer_q == gap_q - 27'd1);
    show_timeout = (timer_q == show_q - 27'd1);

    score_sum  = {1'b0, score_q} + (SCORE_W+1)'(round_q) + (SCORE_W+1)'(1);
    score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
    hits_next  = (round_hits_q == 4'd15) ? 4'd15 : round_hits_q + 4'd1;
    moles_dec  = moles_left_q - 4'd1;
    round_pass = 32'(round_hits_q) >= PASS_HITS;
    last_round = 32'(round_q) >= N_ROUNDS - 1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      gap_q         <= '0;
      show_q        <= '0;
      moles_left_q  <= '0;
      round_hits_q  <= '0;
      lfsr_q        <= 16'hACE1;
      mole_index_q  <= '0;
      mole_active_q <= 1'b0;
      hit_success_q <= 1'b0;
      miss_q        <= 1'b0;
      round_q       <= '0;
      score_q       <= '0;
      game_over_q   <= 1'b0;
      game_won_q    <= 1'b0;
    end else begin
      hit_success_q <= 1'b0;
      miss_q        <= 1'b0;
      if (!frozen) lfsr_q <= lfsr_next;
      unique case (state_q)
        StIdle: if (ctrl.game_start) state_q <= StConfig;
        StConfig: begin
          gap_q        <= gap_cfg;
          show_q       <= show_cfg;
          moles_left_q <= moles_cfg;
          round_hits_q <= '0;
          timer_q      <= '0;
          state_q      <= StGap;
        end
        StGap: if (!frozen) begin
          if (gap_done) begin
            timer_q       <= '0;
            mole_index_q  <= next_mole;
            mole_active_q <= 1'b1;
            state_q       <= StShow;
          end else begin
            timer_q <= timer_q + 27'd1;
          end
        end
        StShow: begin
          if (frozen) begin
            mole_active_q <= 1'b0;
          end else if (correct_hit || show_timeout) begin
            // A correct hit on the last show cycle beats the timeout.
            hit_success_q <= correct_hit;
            miss_q        <= !correct_hit;
            if (correct_hit) begin
              round_hits_q <= hits_next;
              score_q      <= score_next;
            end
            moles_left_q  <= moles_dec;
            mole_active_q <= 1'b0;
            timer_q       <= '0;
            state_q       <= (moles_dec == 4'd0) ? StRoundEnd : StGap;
          end else begin
            timer_q       <= timer_q + 27'd1;
            mole_active_q <= 1'b1;
          end
        end
        StRoundEnd: begin
          if (round_pass && !last_round) begin
            round_q <= round_q + RW'(1);
            state_q <= StConfig;
          end else begin
            game_over_q <= 1'b1;
            game_won_q  <= round_pass;
            state_q     <= StGameOver;
          end
        end
        StGameOver: if (ctrl.game_start) begin
          round_q     <= '0;
          score_q     <= '0;
          game_won_q  <= 1'b0;
          game_over_q <= 1'b0;
          state_q     <= StConfig;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ctrl.mole_active = mole_active_q;
  assign ctrl.mole_index  = mole_index_q;
  assign ctrl.hit_success = hit_success_q;
  assign ctrl.miss        = miss_q;
  assign ctrl.round_level = round_q;
  assign ctrl.round_hits  = round_hits_q;
  assign ctrl.total_score = score_q;
  assign ctrl.game_over   = game_over_q;
  assign ctrl.game_won    = game_won_q;
endmodule

// File: tb/tb_game_ctrl_param.sv
// Bench for game_ctrl_param: a fixed vector table, directed multi-cycle
// scenarios, then random play, all checked against a countdown-style game model.
module tb_game_ctrl_param;
  localparam int N_HOLES = 4, N_ROUNDS = 2, PASS_HITS = 1;
  localparam int INT0 = 4, INT_STEP = 1, DUR0 = 3, DUR_STEP = 1, MOLES0 = 2, MOLES_STEP = 1;
  localparam int P_IDLE = 0, P_CONFIG = 1, P_GAP = 2, P_SHOW = 3, P_REND = 4, P_OVER = 5;

  logic clk, rst;
  game_ctrl_param_if #(.IW(2), .RW(1), .SCORE_W(8)) bus ();

  game_ctrl_param #(
    .N_HOLES(N_HOLES), .N_ROUNDS(N_ROUNDS), .PASS_HITS(PASS_HITS),
    .INT0(INT0), .INT_STEP(INT_STEP), .DUR0(DUR0), .DUR_STEP(DUR_STEP),
    .MOLES0(MOLES0), .MOLES_STEP(MOLES_STEP), .SCORE_W(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctrl(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  // Game model state
  int m_ph, m_left, m_round, m_rhits, m_score, m_mleft, m_mole, m_prev;
  bit m_won, m_over, m_active, m_hs, m_ms, m_new;
  bit [15:0] m_lfsr;

  int rec_mode = 0, seq_k = 0;
  int seq1 [$];

  function automatic int gap_for(input int r);
    int g = INT0 - r * INT_STEP;
    return (g < 1) ? 1 : g;
  endfunction
  function automatic int show_for(input int r);
    int s = DUR0 - r * DUR_STEP;
    return (s < 1) ? 1 : s;
  endfunction
  function automatic int moles_for(input int r);
    int m = MOLES0 + r * MOLES_STEP;
    return (m > 15) ? 15 : m;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int cand;
    m_new = 0;
    m_hs  = 0;
    m_ms  = 0;
    if (rst) begin
      m_ph = P_IDLE; m_left = 0; m_round = 0; m_rhits = 0; m_score = 0; m_mleft = 0;
      m_won = 0; m_over = 0; m_mole = 0; m_active = 0; m_lfsr = 16'hACE1;
    end else if (bus.pause && (m_ph == P_GAP || m_ph == P_SHOW)) begin
      m_active = 0;
    end else begin
      cand   = int'(m_lfsr) % N_HOLES;
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      case (m_ph)
        P_IDLE: if (bus.game_start) m_ph = P_CONFIG;
        P_CONFIG: begin
          m_rhits = 0; m_mleft = moles_for(m_round); m_left = gap_for(m_round); m_ph = P_GAP;
        end
        P_GAP: begin
          m_left--;
          if (m_left == 0) begin
            m_prev = m_mole;
            m_mole = (cand == m_mole) ? (cand + 1) % N_HOLES : cand;
            m_new = 1; m_active = 1; m_left = show_for(m_round); m_ph = P_SHOW;
          end
        end
        P_SHOW: begin
          m_left--;
          if (bus.hit && int'(bus.hit_index) == m_mole) begin
            m_hs = 1;
            m_rhits = (m_rhits + 1 > 15) ? 15 : m_rhits + 1;
            m_score = (m_score + m_round + 1 > 255) ? 255 : m_score + m_round + 1;
          end else if (m_left == 0) begin
            m_ms = 1;
          end
          if (m_hs || m_ms) begin
            m_mleft--; m_active = 0; m_left = gap_for(m_round);
            m_ph = (m_mleft == 0) ? P_REND : P_GAP;
          end else begin
            m_active = 1;
          end
        end
        P_REND: begin
          if (m_rhits >= PASS_HITS && m_round < N_ROUNDS - 1) begin
            m_round++; m_ph = P_CONFIG;
          end else begin
            m_over = 1; m_won = (m_rhits >= PASS_HITS); m_ph = P_OVER;
          end
        end
        P_OVER: if (bus.game_start) begin
          m_round = 0; m_score = 0; m_won = 0; m_over = 0; m_ph = P_CONFIG;
        end
        default: m_ph = P_IDLE;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    chk("mole_active", int'(bus.mole_active), int'(m_active));
    chk("mole_index",  int'(bus.mole_index),  m_mole);
    chk("hit_success", int'(bus.hit_success), int'(m_hs));
    chk("miss",        int'(bus.miss),        int'(m_ms));
    chk("round_level", int'(bus.round_level), m_round);
    chk("round_hits",  int'(bus.round_hits),  m_rhits);
    chk("total_score", int'(bus.total_score), m_score);
    chk("game_over",   int'(bus.game_over),   int'(m_over));
    chk("game_won",    int'(bus.game_won),    int'(m_won));
    if (m_new) chk("mole_no_repeat", int'(int'(bus.mole_index) != m_prev), 1);
    if (m_new && rec_mode == 1) seq1.push_back(m_mole);
    if (m_new && rec_mode == 2) begin
      if (seq_k < seq1.size()) chk("replay_mole", int'(bus.mole_index), seq1[seq_k]);
      seq_k++;
    end
  endtask

  task automatic wait_phase(input int ph);
    int n = 0;
    while (m_ph != ph && n < 100) begin
      tick();
      n++;
    end
    if (m_ph != ph) chk("wait_phase", m_ph, ph);
  endtask

  // Strike every mole on its first visible cycle until the game ends.
  task automatic play_perfect(output int pulses);
    bit done = 0;
    pulses = 0;
    for (int i = 0; i < 300 && !done; i++) begin
      if (m_ph == P_SHOW) begin
        bus.hit = 1'b1;
        bus.hit_index = 2'(m_mole);
      end
      tick();
      bus.hit = 1'b0;
      if (bus.hit_success) pulses++;
      if (m_ph == P_OVER) done = 1;
    end
    chk("perfect_game_ends", int'(done), 1);
  endtask

  typedef struct {
    bit rst; bit gs; bit act; bit hs; bit ms; bit over; bit won;
  } vec_t;
  vec_t tbl [20];

  initial begin
    int pulses, edges, hits_before;
    rst = 1'b1;
    bus.game_start = 1'b0; bus.pause = 1'b0; bus.hit = 1'b0; bus.hit_index = 2'd0;

    // Reset with game_start held, then a game with no strikes.
    for (int i = 0; i < 20; i++) tbl[i] = '{rst: 0, gs: 0, act: 0, hs: 0, ms: 0, over: 0, won: 0};
    tbl[0].rst = 1; tbl[0].gs = 1; tbl[2].gs = 1;
    tbl[7].act = 1; tbl[8].act = 1; tbl[9].act = 1;
    tbl[14].act = 1; tbl[15].act = 1; tbl[16].act = 1;
    tbl[10].ms = 1; tbl[17].ms = 1;
    tbl[18].over = 1; tbl[19].over = 1;
    for (int i = 0; i < 20; i++) begin
      rst = tbl[i].rst;
      bus.game_start = tbl[i].gs;
      tick();
      chk($sformatf("tbl%0d_active", i), int'(bus.mole_active), int'(tbl[i].act));
      chk($sformatf("tbl%0d_hit", i),    int'(bus.hit_success), int'(tbl[i].hs));
      chk($sformatf("tbl%0d_miss", i),   int'(bus.miss),        int'(tbl[i].ms));
      chk($sformatf("tbl%0d_over", i),   int'(bus.game_over),   int'(tbl[i].over));
      chk($sformatf("tbl%0d_won", i),    int'(bus.game_won),    int'(tbl[i].won));
    end
    bus.game_start = 1'b0;
    chk("nohit_score", int'(bus.total_score), 0);
    chk("nohit_round", int'(bus.round_level), 0);

    // Perfect game from reset, recording the mole sequence.
    rst = 1'b1; tick();
    rst = 1'b0; bus.game_start = 1'b1; tick();
    bus.game_start = 1'b0;
    rec_mode = 1;
    play_perfect(pulses);
    rec_mode = 0;
    chk("perfect_pulses", pulses, 5);
    chk("perfect_score", int'(bus.total_score), 8);
    chk("perfect_won", int'(bus.game_won), 1);
    chk("perfect_over", int'(bus.game_over), 1);
    chk("perfect_round", int'(bus.round_level), 1);

    // Restart from game over.
    bus.game_start = 1'b1; tick();
    bus.game_start = 1'b0;
    chk("restart_score", int'(bus.total_score), 0);
    chk("restart_over", int'(bus.game_over), 0);
    chk("restart_won", int'(bus.game_won), 0);

    // Correct hit on the last show cycle.
    wait_phase(P_SHOW);
    for (int i = 0; i < show_for(m_round) - 1; i++) tick();
    bus.hit = 1'b1; bus.hit_index = 2'(m_mole); tick();
    bus.hit = 1'b0;
    chk("late_hit_success", int'(bus.hit_success), 1);
    chk("late_hit_miss", int'(bus.miss), 0);

    // Wrong-index hit is ignored.
    wait_phase(P_SHOW);
    hits_before = m_rhits;
    bus.hit = 1'b1; bus.hit_index = 2'((m_mole + 1) % N_HOLES); tick();
    bus.hit = 1'b0;
    chk("wrong_hit_pulse", int'(bus.hit_success), 0);
    chk("wrong_hit_count", int'(bus.round_hits), hits_before);

    // Pause for 5 cycles at the start of a show, striking the mole meanwhile.
    wait_phase(P_GAP);
    wait_phase(P_SHOW);
    bus.pause = 1'b1; bus.hit = 1'b1; bus.hit_index = 2'(m_mole);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("pause_active", int'(bus.mole_active), 0);
      chk("pause_hit", int'(bus.hit_success), 0);
    end
    bus.pause = 1'b0; bus.hit = 1'b0;
    edges = 5;
    for (int i = 0; i < 20; i++) begin
      tick();
      edges++;
      if (bus.miss) break;
    end
    chk("pause_delay", edges, show_for(m_round) + 5);

    // Reset mid-show, then replay the recorded perfect game.
    wait_phase(P_SHOW);
    tick();
    rst = 1'b1; tick();
    rst = 1'b0; bus.game_start = 1'b1; tick();
    bus.game_start = 1'b0;
    rec_mode = 2; seq_k = 0;
    play_perfect(pulses);
    rec_mode = 0;
    chk("replay_score", int'(bus.total_score), 8);

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      bus.game_start = ($urandom_range(0, 19) == 0);
      bus.pause = ($urandom_range(0, 4) == 0);
      bus.hit = ($urandom_range(0, 2) == 0);
      bus.hit_index = ($urandom_range(0, 1) == 1) ? 2'(m_mole) : 2'($urandom_range(0, 3));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/game_ctrl_param.md
GAME_CTRL_PARAM -- requirements
Module: game_ctrl_param

Interface
REQ-001 SHALL provide parameters (name, default, meaning): N_HOLES, 16, hole count, power of two, 2..16.
REQ-002 SHALL provide parameter N_ROUNDS, 3, number of rounds, 1..8.
REQ-003 SHALL provide parameter PASS_HITS, 3, minimum hits to clear a round.
REQ-004 SHALL provide parameters INT0, 12500000 and INT_STEP, 2500000: gap ticks for round r = max(INT0 - r*INT_STEP, 1).
REQ-005 SHALL provide parameters DUR0, 10000000 and DUR_STEP, 2500000: show ticks for round r = max(DUR0 - r*DUR_STEP, 1).
REQ-006 SHALL provide parameters MOLES0, 4 and MOLES_STEP, 2: moles for round r = min(MOLES0 + r*MOLES_STEP, 15).
REQ-007 SHALL provide parameter SCORE_W, 8, total_score width; all timers are 27 bits.
REQ-008 Ports (name direction width meaning): clk in 1 clock; rst in 1 reset, synchronous, active-high.
REQ-009 game_start in 1 starts or restarts a game; pause in 1 freezes play; hit in 1 one-cycle player strike; hit_index in IW=log2(N_HOLES) struck hole.
REQ-010 mole_active out 1 mole visible; mole_index out IW visible hole; hit_success out 1 one-cycle correct strike; miss out 1 one-cycle mole timeout.
REQ-011 round_level out RW=max(1,clog2(N_ROUNDS)) current round; round_hits out 4 hits this round; total_score out SCORE_W; game_over out 1; game_won out 1.

Function
REQ-012 SHALL implement states IDLE, CONFIG, GAP, SHOW, ROUND_END, GAME_OVER, registered on clk.
REQ-013 IDLE: game_start=1 -> CONFIG next cycle; otherwise hold.
REQ-014 CONFIG (exactly 1 cycle): latch gap/show/moles for round_level per REQ-004..006, clear round_hits, moles_left=moles, timer=0 -> GAP.
REQ-015 GAP: timer increments per unpaused cycle; at timer==gap-1 -> SHOW, timer=0, mole_index loaded per REQ-021; mole_active=0 in GAP.
REQ-016 SHOW: mole_active=1; hit=1 with hit_index==mole_index -> hit_success=1 same cycle as registered next-cycle pulse (1 cycle latency), round_hits+1 (saturate 15), total_score + round_level+1 (saturate all-ones), moles_left-1.
REQ-017 SHOW: hit with wrong index SHALL be ignored; timer==show-1 with no correct hit -> miss pulse (1 cycle latency), moles_left-1.
REQ-018 Correct hit and timeout in same cycle: hit wins, no miss.
REQ-019 After SHOW exit: moles_left reaching 0 -> ROUND_END, else -> GAP with timer=0.
REQ-020 ROUND_END (1 cycle): round_hits>=PASS_HITS and round_level<N_ROUNDS-1 -> round_level+1, CONFIG; round_hits>=PASS_HITS on last round -> GAME_OVER, game_won=1; else GAME_OVER, game_won=0.
REQ-021 Mole position: 16-bit Galois LFSR (taps 0xB400, seed 0xACE1) advancing every unpaused cycle; candidate = lfsr[IW-1:0]; if equal to previous mole_index use candidate+1 mod N_HOLES (no repeat).
REQ-022 pause=1 in GAP/SHOW: timers, LFSR and state freeze, hits ignored, mole_active forced 0, mole_index held; resume continues exactly where frozen.
REQ-023 pause ignored in IDLE, CONFIG, ROUND_END, GAME_OVER.
REQ-024 GAME_OVER: game_over=1, game_won held; game_start=1 -> clear round_level, total_score, game_won -> CONFIG.
REQ-025 game_start outside IDLE/GAME_OVER SHALL be ignored.
REQ-026 hit_success and miss SHALL never be high together and each SHALL be high at most 1 cycle per mole.

Reset
REQ-027 rst=1 SHALL force IDLE, timers 0, LFSR 0xACE1, mole_index 0, and all outputs 0, overriding all inputs including mid-round.
REQ-028 First cycle after rst release SHALL be IDLE regardless of game_start during reset.

Verification (params N_HOLES=4, N_ROUNDS=2, PASS_HITS=1, INT0=4, INT_STEP=1, DUR0=3, DUR_STEP=1, MOLES0=2, MOLES_STEP=1)
REQ-029 game_start, strike every mole correctly -> round 0: 2 moles, gap 4, show 3; round 1: 3 moles, gap 3, show 2; total_score=2*1+3*2=8, game_over=1, game_won=1.
REQ-030 game_start, no hits -> 2 miss pulses, ROUND_END, game_over=1, game_won=0, total_score=0, round_level=0.
REQ-031 Correct hit on final show cycle (timer==2) -> hit_success=1, miss=0.
REQ-032 pause 5 cycles mid-SHOW -> mole_active=0 during pause, mole timeout delayed exactly 5 cycles, wrong/any hits during pause ignored.
REQ-033 Wrong-index hit in SHOW -> no pulse, round_hits unchanged; consecutive mole_index values never equal.
REQ-034 rst mid-SHOW then game_start -> identical mole_index sequence to first game after reset; game_start in GAME_OVER restarts with total_score=0.
